bus_memory_responder: RTL and testbench

- Memory-mapped responder (target) on the shared Gecko5 system bus driven by jtag_support; answers single and burst read/write transactions.
- Internal 32-bit word memory sits in a fixed address window, so the JTAG bus initiator can be exercised on silicon without a real peripheral.
- All bus outputs are zero when not driving, so they can be OR-ed onto the shared bus.

---
 rtl/bus_memory_responder.sv | 186 ++++++++++++++++++
 tb/tb_bus_memory_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: bus target with an internal 32-bit word memory
// mapped at BASE_ADDRESS. Serves single and burst reads/writes on the shared
// Gecko5 bus; every output is zero while the responder is not driving.
// Optional build macro: BUS_ERROR_EN (reject bursts that run past the last
// word, and writes whose first beat has all byte enables clear).
module bus_memory_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
  parameter int unsigned ADDR_BITS    = 8
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  output logic [31:0] address_dataOUT,
  output logic        data_validOUT,
  output logic        end_transactionOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [31:0] BASE_WORD_TAG = BASE_ADDRESS >> (ADDR_BITS + 2);
  localparam logic [ADDR_BITS-1:0] IDX_ONE = ADDR_BITS'(1);
  localparam logic [7:0] CNT_ONE = 8'd1;

  typedef enum logic [2:0] {
    IDLE,
    READ_FETCH,
    READ_BURST,
    READ_END,
    WRITE_SETUP,
    WRITE_BURST,
    ERROR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_BITS-1:0] r_index;
  logic [ADDR_BITS-1:0] w_index_next;
  logic [ADDR_BITS-1:0] w_begin_index;
  logic [7:0]           r_count;
  logic [7:0]           w_count_next;
  logic [7:0]           r_burst;
  logic [7:0]           w_burst_next;
  logic [31:0]          w_word_addr;
  logic                 w_select;
  logic                 w_start_err;
  logic                 w_we;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  // Byte offset bits are dropped; the rest is split into window tag and word index.
  assign w_word_addr   = address_dataIN >> 2;
  assign w_select      = (w_word_addr >> ADDR_BITS) == BASE_WORD_TAG;
  assign w_begin_index = w_word_addr[ADDR_BITS-1:0];

`ifdef BUS_ERROR_EN
  localparam logic [31:0] LAST_INDEX = 32'(DEPTH - 1);
  assign w_start_err = (32'(w_begin_index) + 32'(burst_sizeIN)) > LAST_INDEX;
  assign errorOUT    = (r_state == ERROR);
`else
  assign w_start_err = 1'b0;
  assign errorOUT    = 1'b0;
`endif

  // State and beat bookkeeping registers.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_index <= '0;
      r_count <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      r_index <= w_index_next;
      r_count <= w_count_next;
      r_burst <= w_burst_next;
    end
  end

  // Word memory: byte-lane writes and a registered read of the current index.
  // The read address follows r_index every cycle, so the word fetched in
  // READ_FETCH / READ_BURST appears on r_rdata in the following cycle.
  always_ff @(posedge system_clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_we && byte_enableIN[i]) begin
        r_mem[r_index][8*i +: 8] <= address_dataIN[8*i +: 8];
      end
    end
    r_rdata <= r_mem[r_index];
  end

  // Next-state, index/count updates and bus outputs.
  always_comb begin
    w_next             = r_state;
    w_index_next       = r_index;
    w_count_next       = r_count;
    w_burst_next       = r_burst;
    w_we               = 1'b0;
    address_dataOUT    = '0;
    data_validOUT      = 1'b0;
    end_transactionOUT = 1'b0;
    busyOUT            = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (begin_transactionIN && w_select) begin
          w_index_next = w_begin_index;
          w_count_next = '0;
          w_burst_next = burst_sizeIN;
          if (w_start_err) begin
            w_next = ERROR;
          end else if (read_n_writeIN) begin
            w_next = READ_FETCH;
          end else begin
            w_next = WRITE_SETUP;
          end
        end
      end

      READ_FETCH: begin
        w_index_next = r_index + IDX_ONE;
        w_next       = end_transactionIN ? IDLE : READ_BURST;
      end

      READ_BURST: begin
        data_validOUT   = 1'b1;
        address_dataOUT = r_rdata;
        w_index_next    = r_index + IDX_ONE;
        w_count_next    = r_count + CNT_ONE;
        if (end_transactionIN) begin
          w_next = IDLE;
        end else if (r_count == r_burst) begin
          w_next = READ_END;
        end
      end

      READ_END: begin
        end_transactionOUT = 1'b1;
        w_next             = IDLE;
      end

      WRITE_SETUP: begin
        busyOUT = 1'b1;
        w_next  = end_transactionIN ? IDLE : WRITE_BURST;
      end

      WRITE_BURST: begin
        if (data_validIN) begin
`ifdef BUS_ERROR_EN
          if ((r_count == '0) && (byte_enableIN == 4'b0000)) begin
            w_next = ERROR;
          end else begin
`else
          begin
`endif
            w_we         = 1'b1;
            w_index_next = r_index + IDX_ONE;
            w_count_next = r_count + CNT_ONE;
            if ((r_count == r_burst) || end_transactionIN) begin
              w_next = IDLE;
            end
          end
        end else if (end_transactionIN) begin
          w_next = IDLE;
        end
      end

      ERROR: begin
        w_next = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: a table of single-word
// writes/reads plus hand-written burst, abort, wrap and reset sequences.
module tb_bus_memory_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef logic [31:0] w4_t [0:3];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  logic        system_clock = 1'b0;
  logic        reset_n      = 1'b0;
  logic [31:0] address_dataIN = '0;
  logic [3:0]  byte_enableIN  = '0;
  logic [7:0]  burst_sizeIN   = '0;
  logic        read_n_writeIN = 1'b0;
  logic        begin_transactionIN = 1'b0;
  logic        end_transactionIN   = 1'b0;
  logic        data_validIN        = 1'b0;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  int errors = 0;
  int checks = 0;

  bus_memory_responder #(
    .BASE_ADDRESS(BASE),
    .ADDR_BITS(8)
  ) dut (
    .system_clock(system_clock),
    .reset_n(reset_n),
    .address_dataIN(address_dataIN),
    .byte_enableIN(byte_enableIN),
    .burst_sizeIN(burst_sizeIN),
    .read_n_writeIN(read_n_writeIN),
    .begin_transactionIN(begin_transactionIN),
    .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN),
    .address_dataOUT(address_dataOUT),
    .data_validOUT(data_validOUT),
    .end_transactionOUT(end_transactionOUT),
    .busyOUT(busyOUT),
    .errorOUT(errorOUT)
  );

  always #5 system_clock = ~system_clock;

  function automatic logic [35:0] outs();
    return {address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT};
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  // Write transaction: 'beats' is N+1, 'ndrive' beats are actually offered,
  // end_at is the beat index carrying end_transactionIN (-1 for none).
  task automatic wr_seq(input logic [31:0] addr, input int unsigned beats,
                        input int unsigned ndrive, input w4_t d,
                        input logic [3:0] be, input int end_at);
    address_dataIN      = addr;
    burst_sizeIN        = 8'(beats - 1);
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    chk("wr_setup_busy", outs(), {32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    for (int unsigned i = 0; i < ndrive; i++) begin
      data_validIN      = 1'b1;
      address_dataIN    = d[i];
      byte_enableIN     = be;
      end_transactionIN = (int'(i) == end_at);
      chk("wr_beat_quiet", outs(), 36'h0);
      tick();
    end
    data_validIN      = 1'b0;
    end_transactionIN = 1'b0;
    address_dataIN    = '0;
    byte_enableIN     = '0;
  endtask

  task automatic rd_seq(input string nm, input logic [31:0] addr,
                        input int unsigned beats, input w4_t e);
    address_dataIN      = addr;
    burst_sizeIN        = 8'(beats - 1);
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    chk({nm, "_fetch"}, outs(), 36'h0);
    for (int unsigned k = 0; k < beats; k++) begin
      tick();
      chk({nm, "_beat"}, outs(), {e[k], 1'b1, 1'b0, 1'b0, 1'b0});
    end
    tick();
    chk({nm, "_end"}, outs(), {32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    tick();
    chk({nm, "_idle"}, outs(), 36'h0);
  endtask

  initial begin
    vec_t tbl [0:8];
    w4_t  v;

    tbl[0] = '{1'b1, BASE + 32'h10,  32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, BASE + 32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, BASE + 32'h20,  32'h11223344, 4'hF, 32'h0};
    tbl[3] = '{1'b1, BASE + 32'h20,  32'hAABBCCDD, 4'b0101, 32'h0};
    tbl[4] = '{1'b0, BASE + 32'h20,  32'h0,        4'h0, 32'h11BB33DD};
    tbl[5] = '{1'b1, BASE + 32'h23,  32'h0F0F0F0F, 4'b1000, 32'h0};
    tbl[6] = '{1'b0, BASE + 32'h22,  32'h0,        4'h0, 32'h0FBB33DD};
    tbl[7] = '{1'b1, BASE + 32'h3FC, 32'h12345678, 4'hF, 32'h0};
    tbl[8] = '{1'b0, BASE + 32'h3FC, 32'h0,        4'h0, 32'h12345678};

    // Reset state
    tick();
    chk("reset_outs", outs(), 36'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_outs", outs(), 36'h0);

    // Table of single-word accesses
    for (int i = 0; i < 9; i++) begin
      v = '{tbl[i].data, 32'h0, 32'h0, 32'h0};
      if (tbl[i].wr) begin
        wr_seq(tbl[i].addr, 1, 1, v, tbl[i].be, -1);
      end else begin
        v = '{tbl[i].exp, 32'h0, 32'h0, 32'h0};
        rd_seq("tbl_rd", tbl[i].addr, 1, v);
      end
    end

    // Words 0..2 for the wrap and abort tests
    v = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'h0};
    wr_seq(BASE, 3, 3, v, 4'hF, -1);

    // Full 4-beat burst write and burst read at words 16..19
    v = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    wr_seq(BASE + 32'h40, 4, 4, v, 4'hF, -1);
    rd_seq("burst4", BASE + 32'h40, 4, v);

    // 4-beat write terminated on beat 2, then a stray beat after termination
    v = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hBADBAD00};
    wr_seq(BASE + 32'h40, 4, 4, v, 4'hF, 2);
    v = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hA000_0003};
    rd_seq("wr_abort", BASE + 32'h40, 4, v);

    // Beats beyond N+1 are discarded
    v = '{32'hE000_0002, 32'h0, 32'h0, 32'h0};
    wr_seq(BASE + 32'h88, 1, 1, v, 4'hF, -1);
    v = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'h0};
    wr_seq(BASE + 32'h80, 2, 3, v, 4'hF, -1);
    v = '{32'hD000_0000, 32'hD000_0001, 32'hE000_0002, 32'h0};
    rd_seq("wr_excess", BASE + 32'h80, 3, v);

`ifdef BUS_ERROR_EN
    // Burst past the last word is rejected
    address_dataIN      = BASE + 32'h3FC;
    burst_sizeIN        = 8'd3;
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    chk("wrap_error", outs(), {32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    chk("wrap_error_end", outs(), 36'h0);
    tick();
    chk("wrap_no_data", outs(), 36'h0);

    // All-zero byte enables on the first beat: error, burst discarded
    address_dataIN      = BASE + 32'h10;
    burst_sizeIN        = 8'd1;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    tick();
    data_validIN   = 1'b1;
    address_dataIN = 32'h5555_5555;
    byte_enableIN  = 4'b0000;
    tick();
    chk("be0_error", outs(), {32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    byte_enableIN = 4'hF;
    tick();
    chk("be0_error_end", outs(), 36'h0);
    data_validIN   = 1'b0;
    address_dataIN = '0;
    byte_enableIN  = '0;
    v = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    rd_seq("be0_kept", BASE + 32'h10, 1, v);
`else
    // Burst wraps from the last word to word 0
    v = '{32'h12345678, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002};
    rd_seq("wrap", BASE + 32'h3FC, 4, v);

    // All-zero byte enables are a no-op beat
    v = '{32'h5555_5555, 32'h0, 32'h0, 32'h0};
    wr_seq(BASE + 32'h10, 1, 1, v, 4'b0000, -1);
    v = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    rd_seq("be0_noop", BASE + 32'h10, 1, v);
`endif

    // Unselected read: nothing driven for 10 cycles
    address_dataIN      = 32'h8000_0000;
    burst_sizeIN        = 8'd0;
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    for (int i = 0; i < 10; i++) begin
      chk("unsel_quiet", outs(), 36'h0);
      tick();
    end
    // Unselected write whose index aliases word 4: memory must not change
    address_dataIN      = 32'h8000_0010;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    chk("unsel_wr_no_busy", outs(), 36'h0);
    tick();
    data_validIN   = 1'b1;
    address_dataIN = 32'hBAD0_0000;
    byte_enableIN  = 4'hF;
    tick();
    data_validIN   = 1'b0;
    address_dataIN = '0;
    byte_enableIN  = '0;
    v = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    rd_seq("after_unsel", BASE + 32'h10, 1, v);

    // Read aborted by the initiator on the first beat
    address_dataIN      = BASE;
    burst_sizeIN        = 8'd3;
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    tick();
    chk("rd_abort_beat0", outs(), {32'hC000_0000, 1'b1, 1'b0, 1'b0, 1'b0});
    end_transactionIN = 1'b1;
    tick();
    end_transactionIN = 1'b0;
    chk("rd_abort_drop", outs(), 36'h0);
    tick();
    chk("rd_abort_no_end", outs(), 36'h0);
    tick();
    chk("rd_abort_idle", outs(), 36'h0);

    // Asynchronous reset during read beat 1
    address_dataIN      = BASE;
    burst_sizeIN        = 8'd3;
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    tick();
    tick();
    chk("rst_beat1", outs(), {32'hC000_0001, 1'b1, 1'b0, 1'b0, 1'b0});
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_outs", outs(), 36'h0);
    tick();
    chk("rst_held_outs", outs(), 36'h0);
    reset_n = 1'b1;
    tick();
    chk("rst_release_outs", outs(), 36'h0);
    v = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'h0};
    rd_seq("after_rst", BASE, 3, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
